// File: rtl/fb_scanout_pkg.sv
// Shared constants and types for the framebuffer scan-out block.
package fb_pkg;

  localparam int SRC_W  = 240;
  localparam int SRC_H  = 160;
  localparam int WIN_X0 = 80;
  localparam int WIN_Y0 = 80;

  // Sized screen-space bounds derived from the base geometry.
  localparam logic [9:0]  WIN_X_LO   = 10'(WIN_X0);
  localparam logic [9:0]  WIN_X_HI   = 10'(WIN_X0 + 2 * SRC_W - 1);
  localparam logic [9:0]  WIN_Y_LO   = 10'(WIN_Y0);
  localparam logic [9:0]  WIN_Y_HI   = 10'(WIN_Y0 + 2 * SRC_H - 1);
  localparam logic [9:0]  TRIG_Y_LO  = 10'(WIN_Y0 - 1);
  localparam logic [9:0]  TRIG_Y_HI  = 10'(WIN_Y0 - 1 + 2 * (SRC_H - 1));
  localparam logic [7:0]  COL_LAST   = 8'(SRC_W - 1);
  localparam logic [18:0] ROW_STRIDE = 19'(SRC_W);

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port as seen by the scan-out block, shared via an arbiter.
import fb_pkg::*;

interface fb_scanout_if;
  logic        fb_req;
  logic        fb_gnt;
  logic [18:0] FBread_address;
  pixel_t      FBdata_Out;

  modport master (output fb_req, output FBread_address,
                  input  fb_gnt, input  FBdata_Out);
  modport slave  (input  fb_req, input  FBread_address,
                  output fb_gnt, output FBdata_Out);
endinterface

// File: rtl/fb_scanout_line_buffer.sv
// Two-bank line buffer: one write port, one synchronous read port.
import fb_pkg::*;

module line_buffer_2bank (
  input  logic   Clk,
  input  logic   wr_en,
  input  logic   wr_bank,
  input  logic   [7:0] wr_addr,
  input  pixel_t wr_data,
  input  logic   rd_bank,
  input  logic   [7:0] rd_addr,
  output pixel_t rd_data
);

  pixel_t mem [2][SRC_W];

  // Write the fetched pixel and register the display read.
  // NOTE: the storage array has no reset; RAM contents are never cleared, only overwritten.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/fb_scanout.sv
// Prefetches one 240-pixel source row per pair of screen lines and
// displays the 240x160 framebuffer at 2x scale in a 480x320 window.
import fb_pkg::*;

module fb_scanout (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DRAWX,
  input  logic [9:0] DRAWY,
  fb_scanout_if.master fb,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       underrun
);

  fetch_state_t state;
  logic [9:0]   prev_drawx;
  logic [7:0]   row, col, done_row;
  logic         wr_pending, wr_bank;
  logic [7:0]   wr_col;
  logic         win_q;
  pixel_t       rd_data;

  logic         trig, chk, in_win;
  logic [7:0]   trig_row, line_row, rd_col;

  // Decode the current beam position into fetch trigger, underrun check and read address.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    trig     = 1'b0;
    chk      = 1'b0;
    in_win   = 1'b0;
    trig_row = 8'((DRAWY - TRIG_Y_LO) >> 1);
    line_row = 8'((DRAWY - WIN_Y_LO) >> 1);
    rd_col   = 8'd0;
    if (DRAWX == 10'd0 && prev_drawx != 10'd0 &&
        DRAWY >= TRIG_Y_LO && DRAWY <= TRIG_Y_HI && DRAWY[0] == TRIG_Y_LO[0])
      trig = 1'b1;
    in_win = (DRAWX >= WIN_X_LO) && (DRAWX <= WIN_X_HI) &&
             (DRAWY >= WIN_Y_LO) && (DRAWY <= WIN_Y_HI);
    if (DRAWX == WIN_X_LO && in_win && DRAWY[0] == WIN_Y_LO[0])
      chk = 1'b1;
    if (in_win)
      rd_col = 8'((DRAWX - WIN_X_LO) >> 1);
  end

  // Fetch FSM, write-path staging and the sticky underrun flag.
  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state             <= IDLE;
      fb.fb_req         <= 1'b0;
      fb.FBread_address <= '0;
      row               <= '0;
      col               <= '0;
      done_row          <= '1;
      wr_pending        <= 1'b0;
      wr_bank           <= 1'b0;
      wr_col            <= '0;
      underrun          <= 1'b0;
    end else begin
      // Each granted read lands one cycle later; remember where it goes.
      wr_pending <= fb.fb_req && fb.fb_gnt;
      if (fb.fb_req && fb.fb_gnt) begin
        wr_col  <= col;
        wr_bank <= row[0];
      end
      if (chk && done_row != line_row) underrun <= 1'b1;

      if (trig) begin
        // A new row request while still busy means the previous row lost the race.
        if (state != IDLE) underrun <= 1'b1;
        state             <= FETCH;
        fb.fb_req         <= 1'b1;
        row               <= trig_row;
        col               <= '0;
        fb.FBread_address <= 19'(trig_row) * ROW_STRIDE;
      end else begin
        case (state)
          FETCH: begin
            if (fb.fb_gnt) begin
              if (col == COL_LAST) begin
                state     <= DRAIN;
                fb.fb_req <= 1'b0;
              end else begin
                col               <= col + 8'd1;
                fb.FBread_address <= fb.FBread_address + 19'd1;
              end
            end
          end
          DRAIN: begin
            done_row <= row;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Track the previous column and align the window flag with the RAM read latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_drawx <= '0;
      win_q      <= 1'b0;
    end else begin
      prev_drawx <= DRAWX;
      win_q      <= in_win;
    end
  end

  line_buffer_2bank u_lbuf (
    .Clk     (Clk),
    .wr_en   (wr_pending && !Reset),
    .wr_bank (wr_bank),
    .wr_addr (wr_col),
    .wr_data (fb.FBdata_Out),
    .rd_bank (line_row[0]),
    .rd_addr (rd_col),
    .rd_data (rd_data)
  );

  assign {R, G, B} = win_q ? rd_data : 24'd0;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout.
import fb_pkg::*;

module tb_fb_scanout;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DRAWX, DRAWY;
  logic [7:0] R, G, B;
  logic       underrun;

  int checks   = 0;
  int failures = 0;
  int bank_row [2];

  fb_scanout_if fb_if ();

  fb_scanout dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .DRAWX    (DRAWX),
    .DRAWY    (DRAWY),
    .fb       (fb_if),
    .R        (R),
    .G        (G),
    .B        (B),
    .underrun (underrun)
  );

  always #5 Clk = ~Clk;

  // Framebuffer content as a function of address; all three channels differ.
  function automatic pixel_t pix(input logic [18:0] a);
    return {~a[7:0], a[15:8] ^ 8'h5A, a[7:0]};
  endfunction

  // Framebuffer RAM model: data valid the cycle after the grant cycle.
  always @(posedge Clk)
    if (fb_if.fb_req === 1'b1 && fb_if.fb_gnt === 1'b1)
      fb_if.FBdata_Out <= pix(fb_if.FBread_address);

  // Expected screen colour: 2x upscale of whatever source row each bank holds.
  function automatic logic [23:0] exp_rgb(input int x, input int y);
    if (x >= WIN_X0 && x < WIN_X0 + 2 * SRC_W && y >= WIN_Y0 && y < WIN_Y0 + 2 * SRC_H)
      return pix(19'(bank_row[((y - WIN_Y0) / 2) % 2] * SRC_W + (x - WIN_X0) / 2));
    return 24'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int x, input int y);
    DRAWX = 10'(x);
    DRAWY = 10'(y);
    @(negedge Clk);
  endtask

  task automatic line_start(input int y);
    step(799, y);
    step(0, y);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Follow one row fetch; toggle gives a grant on every second request cycle.
  task automatic run_fetch(input string name, input int row, input bit toggle);
    int n_req = 0;
    int n_gnt = 0;
    for (int c = 0; c < 2 * SRC_W + 20; c++) begin
      if (fb_if.fb_req === 1'b1) begin
        check(name, 32'(fb_if.FBread_address), 32'(row * SRC_W + n_gnt));
        fb_if.fb_gnt = toggle ? n_req[0] : 1'b1;
        if (fb_if.fb_gnt) n_gnt++;
        n_req++;
      end
      step(1 + c, int'(DRAWY));
    end
    check({name, "_req_cycles"}, 32'(n_req), 32'(toggle ? 2 * SRC_W : SRC_W));
    check({name, "_req_low"}, 32'(fb_if.fb_req), 32'd0);
    bank_row[row % 2] = row;
  endtask

  typedef struct {
    int x;
    int y;
    bit vis;
    int src;
  } vec_t;

  vec_t tab0 [10];
  vec_t tab1 [8];

  initial begin
    tab0 = '{'{80, 80, 1, 0}, '{81, 80, 1, 0}, '{82, 80, 1, 1}, '{79, 80, 0, 0},
             '{560, 80, 0, 0}, '{559, 81, 1, 239}, '{80, 81, 1, 0}, '{300, 81, 1, 110},
             '{200, 79, 0, 0}, '{200, 400, 0, 0}};
    tab1 = '{'{80, 398, 1, 38160}, '{82, 398, 1, 38161}, '{559, 399, 1, 38399},
             '{560, 398, 0, 0}, '{320, 80, 1, 120}, '{321, 81, 1, 120},
             '{400, 400, 0, 0}, '{79, 399, 0, 0}};

    Reset = 1'b1;
    DRAWX = 10'd5;
    DRAWY = 10'd0;
    fb_if.fb_gnt = 1'b0;
    do_reset();
    check("rst_req", 32'(fb_if.fb_req), 0);
    check("rst_addr", 32'(fb_if.FBread_address), 0);
    check("rst_rgb", 32'({R, G, B}), 0);
    check("rst_underrun", 32'(underrun), 0);

    // Reset in the middle of a fetch.
    fb_if.fb_gnt = 1'b1;
    line_start(79);
    repeat (10) step(5, 79);
    check("midfetch_req_pre", 32'(fb_if.fb_req), 1);
    do_reset();
    check("midrst_req", 32'(fb_if.fb_req), 0);
    check("midrst_addr", 32'(fb_if.FBread_address), 0);
    check("midrst_rgb", 32'({R, G, B}), 0);
    check("midrst_underrun", 32'(underrun), 0);

    // Row 0, grant held high.
    line_start(79);
    run_fetch("row0_addr", 0, 1'b0);

    // Scaling and window edges with row 0 in bank 0.
    foreach (tab0[i]) begin
      step(tab0[i].x, tab0[i].y);
      check($sformatf("tab0_%0d", i), 32'({R, G, B}),
            tab0[i].vis ? 32'(pix(19'(tab0[i].src))) : 32'd0);
    end
    check("tab0_underrun", 32'(underrun), 0);

    // Row 159 into bank 1, grant toggling, exercising the top address.
    line_start(397);
    run_fetch("row159_addr", 159, 1'b1);
    foreach (tab1[i]) begin
      step(tab1[i].x, tab1[i].y);
      check($sformatf("tab1_%0d", i), 32'({R, G, B}),
            tab1[i].vis ? 32'(pix(19'(tab1[i].src))) : 32'd0);
    end

    // Random beam positions against the upscale model (column 80 would fire the underrun check).
    for (int n = 0; n < 300; n++) begin
      int x, y;
      x = int'($urandom_range(1, 799));
      if (x == WIN_X0) x = WIN_X0 + 1;
      y = int'($urandom_range(0, 524));
      step(x, y);
      check("rand_pix", 32'({R, G, B}), 32'(exp_rgb(x, y)));
    end
    check("pre_underrun", 32'(underrun), 0);

    // Row 1 starved of grants, then overtaken by the row 2 trigger.
    fb_if.fb_gnt = 1'b0;
    line_start(81);
    check("row1_req", 32'(fb_if.fb_req), 1);
    check("row1_addr", 32'(fb_if.FBread_address), 240);
    repeat (3) step(5, 81);
    check("row1_stall_addr", 32'(fb_if.FBread_address), 240);
    check("row1_underrun_lo", 32'(underrun), 0);
    step(80, 82);
    check("underrun_set", 32'(underrun), 1);
    step(81, 82);
    line_start(83);
    check("overlap_addr", 32'(fb_if.FBread_address), 480);
    check("overlap_req", 32'(fb_if.fb_req), 1);
    fb_if.fb_gnt = 1'b1;
    repeat (3) step(5, 83);
    check("overlap_adv_addr", 32'(fb_if.FBread_address), 483);
    check("underrun_sticky", 32'(underrun), 1);
    do_reset();
    check("final_underrun", 32'(underrun), 0);
    check("final_req", 32'(fb_if.fb_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
